// File: rtl/regfile_dump_unit.sv
// Walks every register-file address on one read port and streams each word out LSB byte first.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum byte after the last register.
module regfile_dump_unit #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NB - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
`ifdef REGFILE_DUMP_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_last_byte;
  logic               w_last_reg;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [7:0]         r_csum;
`endif

  assign w_last_byte = (r_cnt == LAST_BYTE);
  assign w_last_reg  = (r_addr == LAST_ADDR);
  assign rd_addr     = r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Outputs decode straight from the state register so reset clears them without a clock edge.
  always_comb begin
    w_state_nxt = r_state;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_LOAD;
      end
      S_LOAD: w_state_nxt = S_SEND;
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = r_shift[7:0];
        if (tx_ready && w_last_byte) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
          w_state_nxt = w_last_reg ? S_CHK : S_LOAD;
`else
          w_state_nxt = w_last_reg ? S_DONE : S_LOAD;
`endif
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      S_CHK: begin
        tx_valid = 1'b1;
        tx_data  = r_csum;
        if (tx_ready) w_state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address only advances after the last byte of a word, and stops at the final register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_addr <= '0;
        S_LOAD: begin
          r_shift <= rd_data;
          r_cnt   <= '0;
        end
        S_SEND: begin
          if (tx_ready) begin
            r_shift <= r_shift >> 8;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last_byte && !w_last_reg) r_addr <= r_addr + 1'b1;
          end
        end
        S_DONE: r_addr <= '0;
        default: ;
      endcase
    end
  end

`ifdef REGFILE_DUMP_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_csum <= 8'h00;
    else if (r_state == S_IDLE && start)  r_csum <= 8'h00;
    else if (r_state == S_SEND && tx_ready) r_csum <= r_csum ^ r_shift[7:0];
  end
`endif

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Bench for regfile_dump_unit: scenario table plus a mid-word async reset sequence, checked
// against a byte-stream model built from the register contents.
module tb_regfile_dump_unit;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NB       = DATA_W / 8;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif
  // Register i loads in cycle 1+5i; last data byte in cycle 160; done one cycle later (+checksum).
  localparam int DONE_CYC = NUM_REGS * (1 + NB) + 1 + CSUM;
  localparam int NCYC     = 500;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] regs [NUM_REGS];
  assign rd_data = regs[rd_addr];

  regfile_dump_unit #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    dpat;     // 0 basic, 1 ramp, 2 random
    int    rmode;    // 0 ready=1, 1 pattern 1,0,0,1, 2 random
    int    sb;       // extra start cycles (-1 none)
    int    sc;
    int    exp_done; // absolute done cycle, -1 if not fixed
  } vec_t;

  vec_t tbl [5];

  int nvec = 0;
  int nmis = 0;
  logic [7:0] got  [$];
  logic [7:0] expq [$];
  int done_n, done_cyc, busy_n, busy_first, busy_last, addr_err, stall_err, hs_last;

  task automatic chk(input string nm, input int a, input int e);
    nvec++;
    if (a != e) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, a, e);
    end
  endtask

  function automatic bit ready_at(input int m, input int c);
    bit r;
    r = 1'b1;
    if (m == 1) begin
      case (c % 4)
        1, 2:    r = 1'b0;
        default: r = 1'b1;
      endcase
    end else if (m == 2) begin
      r = ($urandom_range(0, 3) != 0);
    end
    return r;
  endfunction

  task automatic load_regs(input int dpat);
    for (int i = 0; i < NUM_REGS; i++) begin
      case (dpat)
        0:       regs[i] = (i == 1) ? 32'hDEADBEEF : 32'h0;
        1:       regs[i] = 32'h03020100 + DATA_W'(i) * 32'h04040404;
        default: regs[i] = (i == 0) ? 32'h0 : $urandom;
      endcase
    end
  endtask

  // Expected stream: every register, LSB byte first, then optionally the XOR of all bytes.
  task automatic build_exp();
    logic [7:0] cs;
    cs = 8'h00;
    expq.delete();
    for (int i = 0; i < NUM_REGS; i++) begin
      for (int b = 0; b < NB; b++) begin
        expq.push_back(regs[i][8*b +: 8]);
        cs = cs ^ regs[i][8*b +: 8];
      end
    end
    if (CSUM != 0) expq.push_back(cs);
  endtask

  task automatic run_dump(input int rmode, input int sb, input int sc);
    bit         pv_stall;
    logic [7:0] pv_data;
    logic [ADDR_W-1:0] pv_addr;
    int hs, exp_a;
    got.delete();
    done_n = 0; done_cyc = -1; busy_n = 0; busy_first = -1; busy_last = -1;
    addr_err = 0; stall_err = 0; hs_last = -1; hs = 0;
    pv_stall = 1'b0; pv_data = 8'h00; pv_addr = '0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk); #1;
      start    = (c == 0) || (c == sb) || (c == sc);
      tx_ready = ready_at(rmode, c);
      @(negedge clk);
      if (busy) begin
        busy_n++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
        exp_a = hs / NB;
        if (exp_a > NUM_REGS - 1) exp_a = NUM_REGS - 1;
        if (int'(rd_addr) != exp_a) addr_err++;
      end
      if (done) begin
        done_n++;
        done_cyc = c;
      end
      if (pv_stall && (tx_data != pv_data || rd_addr != pv_addr)) stall_err++;
      pv_stall = tx_valid && !tx_ready;
      pv_data  = tx_data;
      pv_addr  = rd_addr;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        hs++;
        hs_last = c;
      end
    end
    @(posedge clk); #1;
    start    = 1'b0;
    tx_ready = 1'b0;
  endtask

  task automatic check_run(input vec_t v);
    int ndiff, first;
    ndiff = 0; first = -1;
    chk({v.name, "_byte_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      if (got[i] != expq[i]) begin
        ndiff++;
        if (first < 0) first = i;
      end
    end
    chk($sformatf("%s_bad_bytes(first@%0d)", v.name, first), ndiff, 0);
    chk({v.name, "_done_pulses"}, done_n, 1);
    chk({v.name, "_done_after_last_hs"}, done_cyc, hs_last + 1);
    if (v.exp_done >= 0) chk({v.name, "_done_cycle"}, done_cyc, v.exp_done);
    chk({v.name, "_busy_first"}, busy_first, 1);
    chk({v.name, "_busy_cycles"}, busy_n, done_cyc);
    chk({v.name, "_busy_last"}, busy_last, done_cyc);
    chk({v.name, "_addr_seq_errs"}, addr_err, 0);
    if (v.rmode != 0) chk({v.name, "_stall_unstable"}, stall_err, 0);
    chk({v.name, "_idle_addr"}, int'(rd_addr), 0);
    chk({v.name, "_idle_valid"}, int'(tx_valid), 0);
    if (v.dpat == 0 && got.size() >= 8)
      chk("basic_word1_bytes", int'({got[7], got[6], got[5], got[4]}), int'(32'hDEADBEEF));
    if (v.dpat == 0 && got.size() > NUM_REGS * NB)
      chk("basic_checksum", int'(got[NUM_REGS*NB]), int'(8'h22));
  endtask

  initial begin
    vec_t rv;
    int   nval;
    tbl[0] = '{"basic",     0, 0, -1,  -1, DONE_CYC};
    tbl[1] = '{"backpress", 1, 1, -1,  -1, -1};
    tbl[2] = '{"startbusy", 1, 0, 50, 161, DONE_CYC};
    tbl[3] = '{"rand_rdy",  2, 2, -1,  -1, -1};
    tbl[4] = '{"rand_full", 2, 0, -1,  -1, DONE_CYC};

    rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
    load_regs(0);
    #1;
    chk("reset_valid", int'(tx_valid), 0);
    chk("reset_data",  int'(tx_data), 0);
    chk("reset_busy",  int'(busy), 0);
    chk("reset_done",  int'(done), 0);
    chk("reset_addr",  int'(rd_addr), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 5; t++) begin
      load_regs(tbl[t].dpat);
      build_exp();
      run_dump(tbl[t].rmode, tbl[t].sb, tbl[t].sc);
      check_run(tbl[t]);
    end

    // Async reset while byte 2 of register 7 is on the bus.
    load_regs(1);
    for (int c = 0; c <= 39; c++) begin
      @(posedge clk); #1;
      start    = (c == 0);
      tx_ready = 1'b1;
      @(negedge clk);
    end
    chk("rstmid_pre_valid", int'(tx_valid), 1);
    chk("rstmid_pre_addr",  int'(rd_addr), 7);
    chk("rstmid_pre_data",  int'(tx_data), int'(regs[7][23:16]));
    #2 rst = 1'b1;
    #1;
    chk("rstmid_valid", int'(tx_valid), 0);
    chk("rstmid_busy",  int'(busy), 0);
    chk("rstmid_done",  int'(done), 0);
    chk("rstmid_addr",  int'(rd_addr), 0);
    chk("rstmid_data",  int'(tx_data), 0);
    @(negedge clk);
    rst = 1'b0;
    nval = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (tx_valid || busy) nval++;
    end
    chk("rstmid_quiet", nval, 0);
    build_exp();
    run_dump(0, -1, -1);
    rv = '{"restart", 1, 0, -1, -1, DONE_CYC};
    check_run(rv);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/regfile_dump_unit.md
Name: regfile_dump_unit

Overview:
- Read-side initiator for the processor's 32x32 register file.
- On a start pulse it walks every register address on one read port, captures each combinational read word, and streams it out byte-serially on a valid/ready byte interface (debug/trace path).
- Sits beside the register file and drives one of its read-address inputs while the core is halted or in debug.
- Values written to the file during a dump are reported as sampled at each word's LOAD cycle.

Parameters:
- NUM_REGS, 32, number of registers dumped (addresses 0..NUM_REGS-1).
- ADDR_W, 5, read-address width; must satisfy 2^ADDR_W >= NUM_REGS.
- DATA_W, 32, register word width; must be a multiple of 8.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin dump; sampled only in IDLE.
- rd_addr  output  ADDR_W  read address to the register file read port.
- rd_data  input  DATA_W  combinational read data for rd_addr.
- tx_data  output  8  current byte.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  sink accepts the byte when tx_valid and tx_ready are both high at a rising edge.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (async, rst=1): state=IDLE, rd_addr=0, tx_valid=0, tx_data=0, busy=0, done=0, byte counter=0, shift register=0. Takes effect immediately, mid-transfer included; a partially sent word is abandoned and no further bytes are issued.
- States: IDLE, LOAD, SEND, DONE (plus CHK with the optional feature).
- IDLE: start=1 -> LOAD with rd_addr=0. start=0 -> stay.
- LOAD: rd_addr held; at the edge ending LOAD, shift<=rd_data and byte_cnt<=0 -> SEND.
- SEND:
  - tx_valid=1, tx_data=shift[7:0]; bytes are sent LSB first.
  - On handshake: shift>>=8 and byte_cnt++.
  - On handshake of byte DATA_W/8-1: if rd_addr==NUM_REGS-1 -> DONE (or CHK); otherwise rd_addr++ -> LOAD.
  - While tx_valid=1 and tx_ready=0, tx_data and rd_addr hold stable.
- DONE: done=1 for exactly one cycle, busy=1 -> IDLE (rd_addr<=0).
- tx_valid is low in every state except SEND and CHK.
- start is ignored whenever busy=1, including a start coincident with the DONE cycle.
- Throughput with tx_ready held at 1: 1+DATA_W/8 cycles per register.
  - start sampled at the end of cycle 0; LOAD for register i in cycle 1+5i.
  - Last byte handshakes in cycle 160; done=1 in cycle 161.
- rd_addr never exceeds NUM_REGS-1; there is no wrap.
- Register 0 is dumped like any other register (the file returns 0).

Optional Feature:
- Macro: REGFILE_DUMP_CHECKSUM_EN.
- When defined:
  - A running 8-bit XOR of every handshaken data byte is kept; it is cleared on entry to LOAD from IDLE and on reset.
  - After the final register byte the FSM enters CHK, presents tx_valid=1 with tx_data=checksum, and waits for the handshake -> DONE.
  - Total stream is NUM_REGS*DATA_W/8+1 bytes; with ready=1, done occurs in cycle 162.
- When undefined: no CHK state, no checksum register, stream is NUM_REGS*DATA_W/8 bytes.

Test Plan:
- Basic dump: regs[1]=0xDEADBEEF, others 0, tx_ready=1, pulse start -> 128 bytes; bytes 4..7 = EF BE AD DE; all others 00; done=1 in cycle 161 only; busy=1 in cycles 1..161.
- Backpressure: tx_ready toggled 1,0,0,1 repeatedly, regs[i]=0x03020100+i*0x04040404 -> byte stream 00,01,02,...,7F in order with no drops or duplicates; tx_data is stable during every stalled cycle.
- Start while busy: pulse start in cycles 0, 50, and 161 -> exactly one dump of 128 bytes; the cycle-161 start does not begin a second dump.
- Async reset mid-word: assert rst between edges while sending byte 2 of register 7 -> tx_valid, busy, and done go 0 immediately without waiting for a clock edge, rd_addr=0; a subsequent start dumps from register 0 again.
- Address stability: monitor rd_addr -> sequence 0..31, each value held until the handshake of its 4th byte, never reaching 32.
- Checksum (REGFILE_DUMP_CHECKSUM_EN): same data as the basic dump -> 129th byte = 0x22 (EF^BE^AD^DE); done in cycle 162; without the macro the bench sees no 129th byte.
